reg_wb_queue: RTL and testbench

- Writeback queue for multi-cycle results (divider, load miss, etc.) that are headed for the general register file.
- Accepts (rd, data) results over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle into the register file write port (regWrite/rd/writeData) whenever the main pipeline is not using that port.
- Reports which source registers still have queued writes, so decode can stall on RAW hazards.

---
 rtl/reg_wb_queue.sv | 129 ++++++++++++
 tb/tb_reg_wb_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue for multi-cycle results.
// Results are buffered in a small FIFO and drained one per cycle into the
// register file write port whenever the main pipeline leaves it free.
// Per-source pending flags let decode stall on RAW hazards against queued writes.
// Optional build macro WBQ_FWD_EN adds youngest-match forwarding data outputs.
module reg_wb_queue #(
   parameter int DATA_WIDTH_POW = 6,
   parameter int DEPTH_POW      = 2,
   localparam int DATA_WIDTH    = 1 << DATA_WIDTH_POW,
   localparam int DEPTH         = 1 << DEPTH_POW
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic                  enq_valid_in,
   output logic                  enq_ready_out,
   input  logic [4:0]            enq_rd_in,
   input  logic [DATA_WIDTH-1:0] enq_data_in,
   input  logic                  wbPortBusy_in,
   output logic                  regWrite_ctrl_out,
   output logic [4:0]            rd_out,
   output logic [DATA_WIDTH-1:0] writeData_out,
   input  logic [4:0]            rs1_in,
   input  logic [4:0]            rs2_in,
   output logic                  rs1Pending_out,
   output logic                  rs2Pending_out,
`ifdef WBQ_FWD_EN
   output logic [DATA_WIDTH-1:0] rs1FwdData_out,
   output logic [DATA_WIDTH-1:0] rs2FwdData_out,
`endif
   output logic [DEPTH_POW:0]    count_out,
   output logic                  empty_out
);

   localparam logic [DEPTH_POW:0] DEPTH_CNT = (DEPTH_POW+1)'(DEPTH);

   logic [DEPTH_POW-1:0]  head_q, head_d;
   logic [DEPTH_POW-1:0]  tail_q, tail_d;
   logic [DEPTH_POW:0]    count_q, count_d;
   logic [4:0]            rd_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]      slot_valid;
   logic                  empty;
   logic                  full;
   logic                  enq_fire;
   logic                  deq_fire;

   assign empty             = (count_q == '0);
   assign full              = (count_q == DEPTH_CNT);
   // Ready is masked by reset so producers never handshake while the queue is held clear.
   assign enq_ready_out     = reset_n & ~full;
   // x0 completes the handshake but is never stored.
   assign enq_fire          = enq_valid_in & enq_ready_out & (enq_rd_in != 5'd0);
   assign regWrite_ctrl_out = ~empty & ~wbPortBusy_in;
   assign deq_fire          = regWrite_ctrl_out;
   assign rd_out            = empty ? 5'd0 : rd_mem[head_q];
   assign writeData_out     = empty ? '0 : data_mem[head_q];
   assign count_out         = count_q;
   assign empty_out         = empty;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
      case ({enq_fire, deq_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards everything queued.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the valid window, so no reset.
   always_ff @(posedge clk_in) begin
      if (enq_fire) begin
         rd_mem[tail_q]   <= enq_rd_in;
         data_mem[tail_q] <= enq_data_in;
      end
   end

   // A slot is valid when its distance from head is below the occupancy.
   always_comb begin
      slot_valid = '0;
      for (int j = 0; j < DEPTH; j++) begin
         slot_valid[j] = ({1'b0, DEPTH_POW'(j) - head_q} < count_q);
      end
   end

   // Pending flags include the head being written this cycle; the RF update lands after the edge.
   always_comb begin
      rs1Pending_out = 1'b0;
      rs2Pending_out = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         if (slot_valid[j] && (rs1_in != 5'd0) && (rd_mem[j] == rs1_in)) rs1Pending_out = 1'b1;
         if (slot_valid[j] && (rs2_in != 5'd0) && (rd_mem[j] == rs2_in)) rs2Pending_out = 1'b1;
      end
   end

`ifdef WBQ_FWD_EN
   // Walk from oldest to youngest so the last match (youngest value) wins.
   always_comb begin
      rs1FwdData_out = '0;
      rs2FwdData_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, DEPTH_POW'(i)} < count_q) && (rs1_in != 5'd0) &&
             (rd_mem[head_q + DEPTH_POW'(i)] == rs1_in))
            rs1FwdData_out = data_mem[head_q + DEPTH_POW'(i)];
         if (({1'b0, DEPTH_POW'(i)} < count_q) && (rs2_in != 5'd0) &&
             (rd_mem[head_q + DEPTH_POW'(i)] == rs2_in))
            rs2FwdData_out = data_mem[head_q + DEPTH_POW'(i)];
      end
   end
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue: directed stimulus, expected writes queued in a
// scoreboard and checked by a monitor at the falling edge.
module tb_reg_wb_queue;

   logic        clk_in = 1'b0;
   logic        reset_n;
   logic        enq_valid_in;
   logic        enq_ready_out;
   logic [4:0]  enq_rd_in;
   logic [63:0] enq_data_in;
   logic        wbPortBusy_in;
   logic        regWrite_ctrl_out;
   logic [4:0]  rd_out;
   logic [63:0] writeData_out;
   logic [4:0]  rs1_in;
   logic [4:0]  rs2_in;
   logic        rs1Pending_out;
   logic        rs2Pending_out;
`ifdef WBQ_FWD_EN
   logic [63:0] rs1FwdData_out;
   logic [63:0] rs2FwdData_out;
`endif
   logic [2:0]  count_out;
   logic        empty_out;

   int checks = 0;
   int errors = 0;
   logic [68:0] exp_q [$];

   reg_wb_queue #(.DATA_WIDTH_POW(6), .DEPTH_POW(2)) dut (
      .clk_in            (clk_in),
      .reset_n           (reset_n),
      .enq_valid_in      (enq_valid_in),
      .enq_ready_out     (enq_ready_out),
      .enq_rd_in         (enq_rd_in),
      .enq_data_in       (enq_data_in),
      .wbPortBusy_in     (wbPortBusy_in),
      .regWrite_ctrl_out (regWrite_ctrl_out),
      .rd_out            (rd_out),
      .writeData_out     (writeData_out),
      .rs1_in            (rs1_in),
      .rs2_in            (rs2_in),
      .rs1Pending_out    (rs1Pending_out),
      .rs2Pending_out    (rs2Pending_out),
`ifdef WBQ_FWD_EN
      .rs1FwdData_out    (rs1FwdData_out),
      .rs2FwdData_out    (rs2FwdData_out),
`endif
      .count_out         (count_out),
      .empty_out         (empty_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic enq(input logic [4:0] rd, input logic [63:0] data, input bit expect_write);
      enq_valid_in = 1'b1;
      enq_rd_in    = rd;
      enq_data_in  = data;
      if (expect_write) exp_q.push_back({rd, data});
   endtask

   // Monitor: every write the DUT will commit on the next rising edge must match the scoreboard head.
   always @(negedge clk_in) begin
      if (reset_n === 1'b1 && regWrite_ctrl_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rd_out, writeData_out);
         end else begin
            logic [68:0] e;
            e = exp_q.pop_front();
            check("wb_rd", 64'(rd_out), 64'(e[68:64]));
            check("wb_data", writeData_out, e[63:0]);
         end
      end
   end

   initial begin
      reset_n       = 1'b0;
      enq_valid_in  = 1'b0;
      enq_rd_in     = 5'd0;
      enq_data_in   = 64'd0;
      wbPortBusy_in = 1'b0;
      rs1_in        = 5'd0;
      rs2_in        = 5'd0;

      // Reset state
      step();
      step();
      check("rst_ready", 64'(enq_ready_out), 64'd0);
      check("rst_empty", 64'(empty_out), 64'd1);
      check("rst_count", 64'(count_out), 64'd0);
      check("rst_regwrite", 64'(regWrite_ctrl_out), 64'd0);
      check("rst_rd", 64'(rd_out), 64'd0);
      check("rst_data", writeData_out, 64'd0);
      reset_n = 1'b1;
      #1;
      check("release_ready", 64'(enq_ready_out), 64'd1);

      // Single entry, port free: presented next cycle, gone the cycle after
      enq(5'd5, 64'hAA, 1'b1);
      step();
      enq_valid_in = 1'b0;
      check("t1_regwrite", 64'(regWrite_ctrl_out), 64'd1);
      check("t1_rd", 64'(rd_out), 64'd5);
      check("t1_data", writeData_out, 64'hAA);
      check("t1_count", 64'(count_out), 64'd1);
      step();
      check("t1_empty", 64'(empty_out), 64'd1);
      check("t1_count0", 64'(count_out), 64'd0);

      // Fill with port busy, then drain in order
      wbPortBusy_in = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         enq(5'(r), 64'h100 + 64'(r), 1'b1);
         step();
      end
      enq_valid_in = 1'b0;
      check("t2_count_full", 64'(count_out), 64'd4);
      check("t2_ready_full", 64'(enq_ready_out), 64'd0);
      check("t2_regwrite_busy", 64'(regWrite_ctrl_out), 64'd0);
      enq(5'd9, 64'h999, 1'b0);
      step();
      enq_valid_in = 1'b0;
      check("t2_fifth_rejected", 64'(count_out), 64'd4);
      wbPortBusy_in = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         step();
         check("t2_drain_count", 64'(count_out), 64'(k));
      end
      check("t2_empty", 64'(empty_out), 64'd1);

      // rd=0: handshake only
      enq(5'd0, 64'h55, 1'b0);
      #1;
      check("t3_ready", 64'(enq_ready_out), 64'd1);
      step();
      enq_valid_in = 1'b0;
      check("t3_count", 64'(count_out), 64'd0);
      check("t3_regwrite", 64'(regWrite_ctrl_out), 64'd0);
      step();
      check("t3_empty", 64'(empty_out), 64'd1);

      // Same rd twice, pending and youngest forwarding
      wbPortBusy_in = 1'b1;
      enq(5'd7, 64'h11, 1'b1);
      step();
      enq(5'd7, 64'h22, 1'b1);
      step();
      enq_valid_in = 1'b0;
      rs1_in = 5'd7;
      rs2_in = 5'd0;
      #1;
      check("t4_rs1_pending", 64'(rs1Pending_out), 64'd1);
      check("t4_rs2_pending_x0", 64'(rs2Pending_out), 64'd0);
`ifdef WBQ_FWD_EN
      check("t4_rs1_fwd", rs1FwdData_out, 64'h22);
      check("t4_rs2_fwd", rs2FwdData_out, 64'h0);
`endif
      rs2_in = 5'd3;
      #1;
      check("t4_rs2_nomatch", 64'(rs2Pending_out), 64'd0);
      wbPortBusy_in = 1'b0;
      #1;
      check("t4_pending_head", 64'(rs1Pending_out), 64'd1);
      step();
      check("t4_pending_one_left", 64'(rs1Pending_out), 64'd1);
      step();
      check("t4_pending_cleared", 64'(rs1Pending_out), 64'd0);
      check("t4_empty", 64'(empty_out), 64'd1);
      rs1_in = 5'd0;
      rs2_in = 5'd0;

      // Continuous enqueue and drain across pointer wrap
      for (int k = 0; k < 10; k++) begin
         enq(5'((k % 5) + 1), 64'h1000 + 64'(k), 1'b1);
         step();
         check("t5_count", 64'(count_out), 64'd1);
      end
      enq_valid_in = 1'b0;
      step();
      check("t5_drained", 64'(count_out), 64'd0);

      // Async reset mid-drain with three entries queued
      wbPortBusy_in = 1'b1;
      enq(5'd10, 64'hA0, 1'b1);
      step();
      enq(5'd11, 64'hA1, 1'b1);
      step();
      enq(5'd12, 64'hA2, 1'b1);
      step();
      enq_valid_in = 1'b0;
      check("t6_count3", 64'(count_out), 64'd3);
      wbPortBusy_in = 1'b0;
      step();
      check("t6_count2", 64'(count_out), 64'd2);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("t6_rst_regwrite", 64'(regWrite_ctrl_out), 64'd0);
      check("t6_rst_count", 64'(count_out), 64'd0);
      check("t6_rst_empty", 64'(empty_out), 64'd1);
      check("t6_rst_ready", 64'(enq_ready_out), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("t6_post_count", 64'(count_out), 64'd0);
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
